vec3_normalize_seq: RTL



---
 rtl/vec3_normalize_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vec3_normalize_seq.sv
// Multi-cycle Q8.4 3D vector normalizer: shared squarer, bit-serial isqrt, restoring divider.
// Optional build macro VEC3_NORM_ROUND_EN selects round-half-up quotients (default truncates).
module vec3_normalize_seq #(
    parameter int WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic        [WIDTH-1:0] out_len,
    output logic                    out_zero
);

    localparam int FRAC  = 4;
    localparam int Q_W   = FRAC + 1;
    localparam int ACC_W = 2 * WIDTH + 1;
    localparam int DVD_W = WIDTH + FRAC;
    localparam int SQR_W = WIDTH + 2;
    localparam int DIV_W = WIDTH + 1;

    typedef enum logic [2:0] {IDLE, SQ, SQRT, DIV, DONE} state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                           input logic [Q_W-1:0] quo);
        logic signed [WIDTH-1:0] v;
        v = signed'({{(WIDTH-Q_W){1'b0}}, quo});
        return neg ? -v : v;
    endfunction

`ifdef VEC3_NORM_ROUND_EN
    function automatic logic [DVD_W-1:0] round_bias(input logic [WIDTH-2:0] half_len);
        return {{(FRAC+1){1'b0}}, half_len};
    endfunction
`endif

    state_t                  state;
    logic [4:0]              cnt;
    logic [1:0]              comp;
    logic                    neg_x, neg_y, neg_z;
    logic [WIDTH-1:0]        mag_x, mag_y, mag_z;
    logic [ACC_W-1:0]        acc;
    logic [2*WIDTH-1:0]      sq_src;
    logic [WIDTH-1:0]        sq_rem;
    logic [WIDTH-1:0]        root;
    logic [WIDTH-1:0]        dv_rem;
    logic [Q_W-2:0]          q;
    logic signed [WIDTH-1:0] res_x, res_y;

    logic                    neg_sel;
    logic [WIDTH-1:0]        mul_a;
    logic [2*WIDTH-1:0]      prod;
    logic [ACC_W-1:0]        sum_next;
    logic [SQR_W-1:0]        sq_sh, sq_trial;
    logic                    sq_ge;
    logic [DVD_W-1:0]        bias, dividend;
    logic [WIDTH-1:0]        dv_base;
    logic [DIV_W-1:0]        dv_sh;
    logic                    dv_ge;
    logic [Q_W-2:0]          q_base;
    logic [Q_W-1:0]          q_next;

    // comp selects the component for both the squarer and the divider
    always_comb begin
        mul_a   = mag_x;
        neg_sel = neg_x;
        case (comp)
            2'd1:    begin mul_a = mag_y; neg_sel = neg_y; end
            2'd2:    begin mul_a = mag_z; neg_sel = neg_z; end
            default: begin mul_a = mag_x; neg_sel = neg_x; end
        endcase
    end

`ifdef VEC3_NORM_ROUND_EN
    assign bias = round_bias(root[WIDTH-1:1]);
`else
    assign bias = '0;
`endif

    assign prod     = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_a};
    assign sum_next = acc + {1'b0, prod};

    assign sq_sh    = {sq_rem, sq_src[2*WIDTH-1 -: 2]};
    assign sq_trial = {root, 2'b01};
    assign sq_ge    = (sq_sh >= sq_trial);

    // Upper dividend bits preload the remainder; the low Q_W bits feed one per step
    assign dividend = {mul_a, {FRAC{1'b0}}} + bias;
    assign dv_base  = (cnt == '0) ? {1'b0, dividend[DVD_W-1:Q_W]} : dv_rem;
    assign dv_sh    = {dv_base, dividend[4'(Q_W-1) - cnt[3:0]]};
    assign dv_ge    = (dv_sh >= {1'b0, root});
    assign q_base   = (cnt == '0) ? '0 : q;
    assign q_next   = {q_base, dv_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_len   <= '0;
            out_zero  <= 1'b0;
            cnt       <= '0;
            comp      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg_x    <= in_x[WIDTH-1];
                        neg_y    <= in_y[WIDTH-1];
                        neg_z    <= in_z[WIDTH-1];
                        mag_x    <= magnitude(in_x);
                        mag_y    <= magnitude(in_y);
                        mag_z    <= magnitude(in_z);
                        acc      <= '0;
                        comp     <= '0;
                        in_ready <= 1'b0;
                        state    <= SQ;
                    end
                end
                SQ: begin
                    acc <= sum_next;
                    if (comp == 2'd2) begin
                        if (sum_next == '0) begin
                            out_x     <= '0;
                            out_y     <= '0;
                            out_z     <= '0;
                            out_len   <= '0;
                            out_zero  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            sq_src <= sum_next[2*WIDTH-1:0];
                            sq_rem <= '0;
                            root   <= '0;
                            cnt    <= '0;
                            state  <= SQRT;
                        end
                    end else begin
                        comp <= comp + 2'd1;
                    end
                end
                SQRT: begin
                    sq_rem <= sq_ge ? WIDTH'(sq_sh - sq_trial) : sq_sh[WIDTH-1:0];
                    root   <= {root[WIDTH-2:0], sq_ge};
                    sq_src <= sq_src << 2;
                    if (cnt == 5'(WIDTH-1)) begin
                        cnt   <= '0;
                        comp  <= '0;
                        state <= DIV;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV: begin
                    dv_rem <= dv_ge ? WIDTH'(dv_sh - {1'b0, root}) : dv_sh[WIDTH-1:0];
                    q      <= q_next[Q_W-2:0];
                    if (cnt == 5'(Q_W-1)) begin
                        cnt  <= '0;
                        comp <= comp + 2'd1;
                        case (comp)
                            2'd0: res_x <= apply_sign(neg_sel, q_next);
                            2'd1: res_y <= apply_sign(neg_sel, q_next);
                            default: begin
                                out_x     <= res_x;
                                out_y     <= res_y;
                                out_z     <= apply_sign(neg_sel, q_next);
                                out_len   <= root;
                                out_zero  <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
